onehot_decoder_4_2: RTL and testbench

ONEHOT_DECODER_4_2 -- requirements
Module: onehot_decoder_4_2

---
 rtl/onehot_dec_pkg.sv | 29 ++
 rtl/onehot_dec_lut.sv | 37 +++
 rtl/onehot_decoder_4_2.sv | 145 ++++++++++++++
 tb/tb_onehot_decoder_4_2.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/onehot_dec_pkg.sv
// Shared types and constants for the one-hot decoder with result FIFO.
// The optional illegal-code counter is enabled with ONEHOT_DEC_ERR_CNT_EN.
package onehot_dec_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } fifo_state_e;

    // Legal codes; note the zero word is a legal code for index 0.
    localparam logic [3:0] CODE_IDX0 = 4'b0000;
    localparam logic [3:0] CODE_IDX1 = 4'b0010;
    localparam logic [3:0] CODE_IDX2 = 4'b0100;
    localparam logic [3:0] CODE_IDX3 = 4'b1000;

    localparam logic [1:0] ILLEGAL_IDX = 2'b00;

    typedef struct packed {
        logic [1:0] index;
        logic       err;
    } dec_result_t;

    // Two-entry storage, so a pointer simply toggles to wrap 1->0.
    function automatic logic ptr_advance(input logic ptr);
        return ~ptr;
    endfunction

endpackage

// File: rtl/onehot_dec_lut.sv
// Combinational mapping from a 4-bit code to {index, err}.
module onehot_dec_lut
    import onehot_dec_pkg::*;
(
    input  logic [3:0]  code,
    output dec_result_t result
);

    // Decode table; anything not listed is illegal.
    always_comb begin
        result.index = ILLEGAL_IDX;
        result.err   = 1'b1;
        case (code)
            CODE_IDX0: begin
                result.index = 2'b00;
                result.err   = 1'b0;
            end
            CODE_IDX1: begin
                result.index = 2'b01;
                result.err   = 1'b0;
            end
            CODE_IDX2: begin
                result.index = 2'b10;
                result.err   = 1'b0;
            end
            CODE_IDX3: begin
                result.index = 2'b11;
                result.err   = 1'b0;
            end
            default: begin
                result.index = ILLEGAL_IDX;
                result.err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/onehot_decoder_4_2.sv
// One-hot 4->2 decoder feeding a 2-entry result FIFO with valid/ready on both sides.
// Define ONEHOT_DEC_ERR_CNT_EN to add the saturating illegal-code counter (err_cnt/err_clr).
module onehot_decoder_4_2
    import onehot_dec_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_index,
    output logic             out_err
`ifdef ONEHOT_DEC_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
`endif
);

    fifo_state_e state_r;
    fifo_state_e state_nx_s;
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic        ready_en_r;
    dec_result_t mem_r [0:1];
    dec_result_t lut_res_s;
    logic        push_s;
    logic        pop_s;

    onehot_dec_lut u_lut (
        .code   (in_code),
        .result (lut_res_s)
    );

    // ready_en_r keeps in_ready low through reset and for the edge that releases it.
    assign in_ready  = ready_en_r && (state_r != FULL);
    assign out_valid = (state_r != EMPTY);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign out_index = mem_r[rd_ptr_r].index;
    assign out_err   = mem_r[rd_ptr_r].err;

    // Ready-enable flag: set on the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Occupancy next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            EMPTY: begin
                if (push_s) begin
                    state_nx_s = ONE;
                end else begin
                    state_nx_s = EMPTY;
                end
            end
            ONE: begin
                if (push_s && !pop_s) begin
                    state_nx_s = FULL;
                end else if (pop_s && !push_s) begin
                    state_nx_s = EMPTY;
                end else begin
                    state_nx_s = ONE;
                end
            end
            FULL: begin
                if (pop_s) begin
                    state_nx_s = ONE;
                end else begin
                    state_nx_s = FULL;
                end
            end
            default: begin
                state_nx_s = EMPTY;
            end
        endcase
    end

    // Read and write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_advance(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_advance(rd_ptr_r);
            end
        end
    end

    // Result storage; the head slot is never written while it is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= '{index: ILLEGAL_IDX, err: 1'b0};
            mem_r[1] <= '{index: ILLEGAL_IDX, err: 1'b0};
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= lut_res_s;
        end
    end

`ifdef ONEHOT_DEC_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] err_cnt_r;

    assign err_cnt = err_cnt_r;

    // Saturating illegal-code counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= '0;
        end else if (err_clr) begin
            err_cnt_r <= '0;
        end else if (push_s && lut_res_s.err && (err_cnt_r != CNT_MAX)) begin
            err_cnt_r <= err_cnt_r + CNT_ONE;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_onehot_decoder_4_2.sv
// Directed self-checking bench for onehot_decoder_4_2 (counter checks when ONEHOT_DEC_ERR_CNT_EN is defined).
module tb_onehot_decoder_4_2;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_index;
    logic       out_err;
`ifdef ONEHOT_DEC_ERR_CNT_EN
    logic [7:0] err_cnt;
    logic       err_clr;
`endif

    int checks;
    int errors;

    onehot_decoder_4_2 #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_err   (out_err)
`ifdef ONEHOT_DEC_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] idx, input logic e);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_index"}, 32'(out_index), 32'(idx));
        chk({tag, "_err"},   32'(out_err),   32'(e));
    endtask

    // Single push into an empty FIFO with out_ready=1, check result, let it pop.
    task automatic push_one(input string tag, input logic [3:0] code,
                            input logic [1:0] idx, input logic e);
        in_valid = 1'b1;
        in_code  = code;
        tick();
        in_valid = 1'b0;
        in_code  = 4'b1111;
        chk_out(tag, 1'b1, idx, e);
        tick();
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 4'b0000;
        out_ready = 1'b1;
`ifdef ONEHOT_DEC_ERR_CNT_EN
        err_clr   = 1'b0;
`endif
        tick();
        tick();
        chk_out("rst", 1'b0, 2'b00, 1'b0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef ONEHOT_DEC_ERR_CNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("rel_in_ready_high", 32'(in_ready), 32'd1);

        // Single pushes with 1-cycle latency.
        push_one("p0100", 4'b0100, 2'b10, 1'b0);
        push_one("p0110", 4'b0110, 2'b00, 1'b1);
`ifdef ONEHOT_DEC_ERR_CNT_EN
        chk("cnt_after_0110", 32'(err_cnt), 32'd1);
`endif
        push_one("p0000", 4'b0000, 2'b00, 1'b0);
        push_one("p0010", 4'b0010, 2'b01, 1'b0);
        push_one("p0001", 4'b0001, 2'b00, 1'b1);
        push_one("p1000", 4'b1000, 2'b11, 1'b0);

        // in_valid low: code ignored.
        in_code = 4'b0100;
        tick();
        chk("idle_no_valid", 32'(out_valid), 32'd0);

        // Fill to FULL with downstream stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 4'b1000;
        tick();
        in_code   = 4'b0010;
        tick();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk_out("full_head", 1'b1, 2'b11, 1'b0);
        in_code   = 4'b0100;
        tick();
        in_valid  = 1'b0;
        chk_out("full_hold", 1'b1, 2'b11, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_out("pop2", 1'b1, 2'b01, 1'b0);
        chk("pop2_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Streaming in ONE: one result per cycle, order kept.
        in_valid = 1'b1;
        in_code  = 4'b0010;
        tick();
        chk_out("s0", 1'b1, 2'b01, 1'b0);
        in_code  = 4'b1000;
        tick();
        chk_out("s1", 1'b1, 2'b11, 1'b0);
        chk("s1_in_ready", 32'(in_ready), 32'd1);
        in_code  = 4'b0000;
        tick();
        chk_out("s2", 1'b1, 2'b00, 1'b0);
        in_code  = 4'b0111;
        tick();
        chk_out("s3", 1'b1, 2'b00, 1'b1);
        chk("s3_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("stream_empty", 32'(out_valid), 32'd0);

`ifdef ONEHOT_DEC_ERR_CNT_EN
        chk("cnt_before_sat", 32'(err_cnt), 32'd3);
        in_valid = 1'b1;
        in_code  = 4'b1111;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        chk("cnt_sat", 32'(err_cnt), 32'd255);
        err_clr = 1'b1;
        tick();
        chk("cnt_clr_prio", 32'(err_cnt), 32'd0);
        err_clr  = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("cnt_after_clr", 32'(err_cnt), 32'd0);
        chk("sat_drain", 32'(out_valid), 32'd0);
`endif

        // Reset while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 4'b1000;
        tick();
        in_code   = 4'b1100;
        tick();
        in_valid  = 1'b0;
        chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
`ifdef ONEHOT_DEC_ERR_CNT_EN
        chk("pre_rst_cnt", 32'(err_cnt), 32'd1);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 2'b00, 1'b0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
`ifdef ONEHOT_DEC_ERR_CNT_EN
        chk("mid_rst_cnt", 32'(err_cnt), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        push_one("post_rst", 4'b0010, 2'b01, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
